// File: rtl/insert_win_sched_pkg.sv
// Shared FSM encoding and clamp helpers for the windowed inserter scheduler.
package insert_win_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Largest probability with a clear MSB: {0, all ones}.
  function automatic int prob_max(input int fbitwidth);
    return (1 << (fbitwidth - 1)) - 1;
  endfunction

  // Largest log2 window whose 1<<log2 still fits the window/counter width.
  function automatic int winlog2_max(input int bitwidth);
    return bitwidth - 1;
  endfunction

endpackage

// File: rtl/insert_win_sched_rr_pick.sv
// Stateless round-robin picker: first requester at or after i_ptr, wrapping, gets a one-hot grant.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt
);

  always_comb begin
    logic w_found;
    int   w_idx;
    w_found = 1'b0;
    w_idx   = 0;
    o_gnt   = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_idx = int'(i_ptr) + j;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/insert_win_sched.sv
// Round-robin window scheduler driving one shared inserter: IDLE -> LOAD -> RUN(window) -> FLUSH.
// Optional INSERT_SCHED_ONESCNT_EN adds iBit/oOnes to count inserter ones over each window.
module insert_win_sched
  import insert_win_sched_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int BITWIDTH     = 8,
  parameter int BITWIDTHLOG2 = 3,
  parameter int FBITWIDTH    = 4
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [NREQ-1:0]           iReq,
  input  logic [NREQ*FBITWIDTH-1:0] iProb,
  input  logic [BITWIDTHLOG2-1:0]   iWinLog2,
`ifdef INSERT_SCHED_ONESCNT_EN
  input  logic                      iBit,
  output logic [BITWIDTH:0]         oOnes,
`endif
  output logic [NREQ-1:0]           oGnt,
  output logic                      oEn,
  output logic                      oClr,
  output logic [FBITWIDTH-1:0]      oProb,
  output logic [BITWIDTH-1:0]       oWindow,
  output logic [BITWIDTHLOG2-1:0]   oWinLog2,
  output logic [NREQ-1:0]           oDone,
  output logic                      oBusy
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [FBITWIDTH-1:0]    LP_PROB_MAX = FBITWIDTH'(prob_max(FBITWIDTH));
  localparam logic [BITWIDTHLOG2-1:0] LP_WL2_MAX  = BITWIDTHLOG2'(winlog2_max(BITWIDTH));

  state_t                  r_state;
  logic [PTRW-1:0]         r_ptr;
  logic [BITWIDTH-1:0]     r_cnt;

  state_t                  w_state_nxt;
  logic [NREQ-1:0]         w_pick;
  logic [NREQ-1:0]         w_gnt_nxt;
  logic                    w_en_nxt;
  logic                    w_clr_nxt;
  logic [NREQ-1:0]         w_done_nxt;
  logic [BITWIDTH-1:0]     w_cnt_nxt;
  logic [PTRW-1:0]         w_ptr_nxt;
  logic [FBITWIDTH-1:0]    w_prob_nxt;
  logic [BITWIDTH-1:0]     w_window_nxt;
  logic [BITWIDTHLOG2-1:0] w_wl2_nxt;

  logic [PTRW-1:0]         w_gnt_idx;
  logic [PTRW-1:0]         w_ptr_inc;
  logic [FBITWIDTH-1:0]    w_prob_sel;
  logic [FBITWIDTH-1:0]    w_prob_clamp;
  logic [BITWIDTHLOG2-1:0] w_wl2_clamp;
  logic [BITWIDTH-1:0]     w_window_new;

  rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr_pick (
    .i_req (iReq),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  // Granted index and its probability slice, decoded from the held one-hot grant.
  always_comb begin
    w_gnt_idx  = '0;
    w_prob_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (oGnt[k]) begin
        w_gnt_idx  = PTRW'(k);
        w_prob_sel = iProb[k*FBITWIDTH +: FBITWIDTH];
      end
    end
  end

  assign w_prob_clamp = w_prob_sel[FBITWIDTH-1] ? LP_PROB_MAX : w_prob_sel;
  assign w_wl2_clamp  = (iWinLog2 > LP_WL2_MAX) ? LP_WL2_MAX : iWinLog2;
  assign w_window_new = BITWIDTH'(1) << w_wl2_clamp;
  assign w_ptr_inc    = (w_gnt_idx == PTRW'(NREQ - 1)) ? '0 : w_gnt_idx + PTRW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = oGnt;
    w_en_nxt     = 1'b0;
    w_clr_nxt    = 1'b0;
    w_done_nxt   = '0;
    w_cnt_nxt    = r_cnt;
    w_ptr_nxt    = r_ptr;
    w_prob_nxt   = oProb;
    w_window_nxt = oWindow;
    w_wl2_nxt    = oWinLog2;
    case (r_state)
      ST_IDLE: begin
        if (|iReq) begin
          w_state_nxt = ST_LOAD;
          w_gnt_nxt   = w_pick;
          w_clr_nxt   = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_nxt  = ST_RUN;
        w_prob_nxt   = w_prob_clamp;
        w_wl2_nxt    = w_wl2_clamp;
        w_window_nxt = w_window_new;
        w_cnt_nxt    = w_window_new - BITWIDTH'(1);
        w_en_nxt     = 1'b1;
      end
      ST_RUN: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_FLUSH;
          w_done_nxt  = oGnt;
        end else begin
          w_cnt_nxt = r_cnt - BITWIDTH'(1);
          w_en_nxt  = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_ptr_nxt   = w_ptr_inc;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      oGnt     <= '0;
      oEn      <= 1'b0;
      oClr     <= 1'b0;
      oProb    <= '0;
      oWindow  <= '0;
      oWinLog2 <= '0;
      oDone    <= '0;
      oBusy    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      oGnt     <= w_gnt_nxt;
      oEn      <= w_en_nxt;
      oClr     <= w_clr_nxt;
      oProb    <= w_prob_nxt;
      oWindow  <= w_window_nxt;
      oWinLog2 <= w_wl2_nxt;
      oDone    <= w_done_nxt;
      oBusy    <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef INSERT_SCHED_ONESCNT_EN
  localparam int OW = BITWIDTH + 1;

  // Cleared on entry to LOAD; each oEn cycle adds the inserter bit, so the total lands in FLUSH.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oOnes <= '0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_LOAD) begin
      oOnes <= '0;
    end else if (oEn) begin
      oOnes <= oOnes + OW'(iBit);
    end
  end
`endif

endmodule

// File: doc/insert_win_sched.md
INSERT_WIN_SCHED -- requirements
Module: insert_win_sched

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; BITWIDTH, default 8, window and counter width; BITWIDTHLOG2, default 3, width of the log2 window field; FBITWIDTH, default 4, probability width.
REQ-002 Clocking and reset SHALL be one clock and an asynchronous, active-high reset; ports are listed below as name, direction, width, meaning.
REQ-003 iClk  in  1  sole clock, rising edge.
REQ-004 iRst  in  1  asynchronous reset, active-high.
REQ-005 iReq  in  NREQ  per-requester window request, level-sensitive.
REQ-006 iProb  in  NREQ*FBITWIDTH  per-requester probability; slice k belongs to requester k.
REQ-007 iWinLog2  in  BITWIDTHLOG2  log2 of the window length, shared by all requesters.
REQ-008 oGnt  out  NREQ  one-hot grant, held from LOAD through FLUSH.
REQ-009 oEn, oClr  out  1 each  enable and clear to the shared inserter.
REQ-010 oProb, oWindow, oWinLog2  out  FBITWIDTH, BITWIDTH, BITWIDTHLOG2  latched inserter configuration.
REQ-011 oDone  out  NREQ  one-cycle one-hot pulse marking the end of the granted window.
REQ-012 oBusy  out  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, LOAD, RUN and FLUSH; all outputs are registered.
REQ-014 IDLE: if any iReq bit is high, the block SHALL select the requester by round-robin starting at pointer ptr, set oGnt, and go to LOAD next cycle; otherwise it stays in IDLE.
REQ-015 LOAD (1 cycle): the block SHALL assert oClr=1 and oEn=0 and latch oProb, oWinLog2, and oWindow = 1 << oWinLog2; it then goes to RUN.
REQ-016 RUN: the block SHALL hold oEn=1 for exactly oWindow cycles, with a down-counter loaded with oWindow-1 that goes to FLUSH when it reaches 0.
REQ-017 FLUSH (1 cycle): oEn=0, oDone = oGnt, ptr = granted index + 1 modulo NREQ; the next state is IDLE.
REQ-018 Per-window occupancy SHALL be oWindow+3 cycles, counted from the IDLE cycle that sees the request to the IDLE cycle after FLUSH.
REQ-019 Dropping iReq after the grant SHALL NOT abort the window; the window runs to completion.
REQ-020 A requester whose iReq is still high in IDLE after its own oDone SHALL lose priority to any other pending requester.
REQ-021 Probability clamp: if the iProb slice MSB is 1, oProb SHALL be set to {0, all ones}.
REQ-022 Window clamp: if iWinLog2 > BITWIDTH-1, oWinLog2 SHALL be set to BITWIDTH-1.
REQ-023 Changes to iProb or iWinLog2 outside LOAD SHALL have no effect on the window in progress.
REQ-024 oClr and oEn SHALL never be high in the same cycle.

Reset
REQ-025 On iRst, all outputs SHALL be forced to 0 asynchronously, the state to IDLE, ptr to 0 and the RUN counter to 0.
REQ-026 Reset asserted mid-RUN SHALL drop oEn in the same cycle, produce no oDone, and restart with ptr=0.

Configuration
REQ-027 With INSERT_SCHED_ONESCNT_EN defined, the block SHALL add input iBit (1, the inserter output) and output oOnes (BITWIDTH+1).
REQ-028 With INSERT_SCHED_ONESCNT_EN defined, oOnes SHALL count iBit=1 on cycles where oEn was high in the previous cycle, clear in LOAD, and be valid while oDone is high.
REQ-029 Without INSERT_SCHED_ONESCNT_EN, iBit, oOnes and the counter SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE, LOAD, RUN, FLUSH) and the clamp constants for the probability maximum and the maximum log2 window.
REQ-031 The round-robin priority selector SHALL be a separate sub-module rr_pick (inputs: request vector and pointer; output: one-hot grant), with no state of its own.

Verification
REQ-032 Single request: iReq=4'b0001, iProb=4'b0011, iWinLog2=3 -> LOAD with oClr pulse, 8 cycles oEn, oDone=4'b0001 in cycle 11, oProb=3, oWindow=8.
REQ-033 All requests held high: iReq=4'b1111 continuously -> grant order 0,1,2,3,0, each window 11 cycles with iWinLog2=3.
REQ-034 Clamps: iProb=4'b1010 with iWinLog2=7 at BITWIDTH=8 -> oProb=4'b0111, oWindow=128; iWinLog2=7 at BITWIDTH=6 -> oWinLog2=5, oWindow=32.
REQ-035 Request dropped at RUN cycle 2 -> oEn stays high for the full window and oDone still pulses.
REQ-036 iRst pulsed at RUN cycle 4 -> oEn, oGnt and oBusy go to 0 immediately with no oDone, and the next grant goes to requester 0.
REQ-037 With INSERT_SCHED_ONESCNT_EN, iBit tied to 1, iWinLog2=2 -> oOnes=4 at oDone.
